// File: rtl/acc_req_adapter.sv
// Decoupling stage between the accelerator dispatcher and the accelerator.
// Buffers requests in a FIFO, issues them under an outstanding limit and a
// per-ID in-flight table, and returns registered responses.
//
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   req_*                       upstream request handshake and payload
//   acc_valid_o/acc_ready_i     downstream issue handshake
//   acc_insn/rs1/rs2/trans_id_o FIFO head payload
//   acc_resp_*_i                accelerator response strobe (no backpressure)
//   resp_*_o                    registered response to dispatcher
//   load/store_complete_o       completion pulses
//   store_pending_o             any store buffered or in flight
//   spurious_resp_o             response for an ID that was not in flight
//   outstanding_o               in-flight count
module acc_req_adapter #(
    parameter int unsigned TransIdBits    = 3,
    parameter int unsigned XLEN           = 64,
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [31:0]                      req_insn_i,
    input  logic [XLEN-1:0]                  req_rs1_i,
    input  logic [XLEN-1:0]                  req_rs2_i,
    input  logic [TransIdBits-1:0]           req_trans_id_i,
    input  logic                             req_is_load_i,
    input  logic                             req_is_store_i,
    output logic                             acc_valid_o,
    input  logic                             acc_ready_i,
    output logic [31:0]                      acc_insn_o,
    output logic [XLEN-1:0]                  acc_rs1_o,
    output logic [XLEN-1:0]                  acc_rs2_o,
    output logic [TransIdBits-1:0]           acc_trans_id_o,
    input  logic                             acc_resp_valid_i,
    input  logic [TransIdBits-1:0]           acc_resp_trans_id_i,
    input  logic [XLEN-1:0]                  acc_resp_result_i,
    input  logic                             acc_resp_error_i,
    output logic                             resp_valid_o,
    output logic [TransIdBits-1:0]           resp_trans_id_o,
    output logic [XLEN-1:0]                  resp_result_o,
    output logic                             resp_error_o,
    output logic                             load_complete_o,
    output logic                             store_complete_o,
    output logic                             store_pending_o,
    output logic                             spurious_resp_o,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);

    localparam int unsigned NumIds = 1 << TransIdBits;
    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CntW   = $clog2(Depth + 1);
    localparam int unsigned OutW   = $clog2(MaxOutstanding + 1);

    localparam logic [CntW-1:0] CntFull = CntW'(Depth);
    localparam logic [OutW-1:0] OutMax  = OutW'(MaxOutstanding);

    typedef struct packed {
        logic [31:0]            insn;
        logic [XLEN-1:0]        rs1;
        logic [XLEN-1:0]        rs2;
        logic [TransIdBits-1:0] id;
        logic                   ld;
        logic                   st;
    } entry_t;

    entry_t                 mem_q [Depth];
    logic [PtrW-1:0]        wptr_q, rptr_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CntW-1:0]        st_buf_q, st_buf_d;
    logic [NumIds-1:0]      inflight_q, inflight_d;
    logic [NumIds-1:0]      is_ld_q, is_ld_d;
    logic [NumIds-1:0]      is_st_q, is_st_d;
    logic [OutW-1:0]        outst_q, outst_d;

    logic                   resp_valid_q;
    logic [TransIdBits-1:0] resp_id_q;
    logic [XLEN-1:0]        resp_result_q;
    logic                   resp_error_q;
    logic                   ld_cmp_q, st_cmp_q, spur_q;

    entry_t head;
    entry_t wr_entry;
    logic   full, empty, push, pop, resp_hit, resp_spur;

    assign head      = mem_q[rptr_q];
    assign full      = (cnt_q == CntFull);
    assign empty     = (cnt_q == '0);
    assign push      = req_valid_i & ~full;
    assign pop       = acc_valid_o & acc_ready_i;
    // Response legality is judged on the table as it stood before this edge.
    assign resp_hit  = acc_resp_valid_i &  inflight_q[acc_resp_trans_id_i];
    assign resp_spur = acc_resp_valid_i & ~inflight_q[acc_resp_trans_id_i];

    assign wr_entry = '{insn: req_insn_i, rs1: req_rs1_i, rs2: req_rs2_i,
                        id: req_trans_id_i, ld: req_is_load_i,
                        st: req_is_store_i};

    always_comb begin
        inflight_d = inflight_q;
        is_ld_d    = is_ld_q;
        is_st_d    = is_st_q;
        if (resp_hit) inflight_d[acc_resp_trans_id_i] = 1'b0;
        // A hit ID is never the head ID (head is blocked while in flight).
        if (pop) begin
            inflight_d[head.id] = 1'b1;
            is_ld_d[head.id]    = head.ld;
            is_st_d[head.id]    = head.st;
        end
        outst_d = outst_q;
        if (pop && !resp_hit)      outst_d = outst_q + 1'b1;
        else if (!pop && resp_hit) outst_d = outst_q - 1'b1;
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
        st_buf_d = st_buf_q;
        if ((push & req_is_store_i) && !(pop & head.st))
            st_buf_d = st_buf_q + 1'b1;
        else if (!(push & req_is_store_i) && (pop & head.st))
            st_buf_d = st_buf_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
            st_buf_q      <= '0;
            inflight_q    <= '0;
            is_ld_q       <= '0;
            is_st_q       <= '0;
            outst_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_error_q  <= 1'b0;
            ld_cmp_q      <= 1'b0;
            st_cmp_q      <= 1'b0;
            spur_q        <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wr_entry;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            cnt_q        <= cnt_d;
            st_buf_q     <= st_buf_d;
            inflight_q   <= inflight_d;
            is_ld_q      <= is_ld_d;
            is_st_q      <= is_st_d;
            outst_q      <= outst_d;
            resp_valid_q <= resp_hit;
            if (resp_hit) begin
                resp_id_q     <= acc_resp_trans_id_i;
                resp_result_q <= acc_resp_result_i;
                resp_error_q  <= acc_resp_error_i;
            end
            ld_cmp_q <= resp_hit & is_ld_q[acc_resp_trans_id_i];
            st_cmp_q <= resp_hit & is_st_q[acc_resp_trans_id_i];
            spur_q   <= resp_spur;
        end
    end

    assign req_ready_o      = ~full;
    assign acc_valid_o      = ~empty & (outst_q < OutMax)
                            & ~inflight_q[head.id];
    assign acc_insn_o       = head.insn;
    assign acc_rs1_o        = head.rs1;
    assign acc_rs2_o        = head.rs2;
    assign acc_trans_id_o   = head.id;
    assign resp_valid_o     = resp_valid_q;
    assign resp_trans_id_o  = resp_id_q;
    assign resp_result_o    = resp_result_q;
    assign resp_error_o     = resp_error_q;
    assign load_complete_o  = ld_cmp_q;
    assign store_complete_o = st_cmp_q;
    assign spurious_resp_o  = spur_q;
    assign outstanding_o    = outst_q;
    assign store_pending_o  = (st_buf_q != '0) | (|(inflight_q & is_st_q));

endmodule
